// File: rtl/ahb_slave_if.sv
// AHB slave front end: turns each valid AHB transfer into one request/acknowledge
// backend access, with wait states, the two-cycle ERROR response and a wait timeout.
module ahb_slave_if #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        ahb_clk_in,
  input  logic                        ahb_rstn_in,
  input  logic                        ahb_sel_in,
  input  logic [AHB_ADDR_WIDTH-1:0]   ahb_addr_in,
  input  logic [1:0]                  ahb_trans_in,
  input  logic                        ahb_write_in,
  input  logic [2:0]                  ahb_size_in,
  input  logic [2:0]                  ahb_burst_in,
  input  logic [AHB_DATA_WIDTH/8-1:0] ahb_strb_in,
  input  logic [AHB_DATA_WIDTH-1:0]   ahb_wdata_in,
  input  logic                        ahb_ready_in,
  output logic                        ahb_readyout_out,
  output logic                        ahb_resp_out,
  output logic [AHB_DATA_WIDTH-1:0]   ahb_rdata_out,
  output logic                        slv_valid_out,
  output logic                        slv_write_out,
  output logic [AHB_ADDR_WIDTH-1:0]   slv_addr_out,
  output logic [2:0]                  slv_size_out,
  output logic [AHB_DATA_WIDTH/8-1:0] slv_strb_out,
  output logic [AHB_DATA_WIDTH-1:0]   slv_wdata_out,
  input  logic                        slv_ready_in,
  input  logic                        slv_error_in,
  input  logic [AHB_DATA_WIDTH-1:0]   slv_rdata_in
);

  localparam int         STRB_W   = AHB_DATA_WIDTH / 8;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] ERR1   = 2'd2;
  localparam logic [1:0] ERR2   = 2'd3;

  logic [1:0]                state_r;
  logic [1:0]                state_nxt_s;
  logic [AHB_ADDR_WIDTH-1:0] addr_r;
  logic                      write_r;
  logic [2:0]                size_r;
  logic [7:0]                cnt_r;
  logic [AHB_DATA_WIDTH-1:0] rdata_r;
  logic                      sample_s;
  logic                      valid_s;
  logic                      done_s;
  logic                      capture_s;
  logic                      unused_s;

  function automatic logic xfer_ok(input logic [AHB_ADDR_WIDTH-1:0] addr,
                                   input logic [2:0] size);
    logic misaligned;
    misaligned = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if ((3'(i) < size) && addr[i]) begin
        misaligned = 1'b1;
      end
    end
    return (size <= MAX_SIZE) && !misaligned;
  endfunction

  assign unused_s  = ^ahb_burst_in;
  assign sample_s  = ahb_sel_in & ahb_ready_in & ahb_trans_in[1];
  assign valid_s   = xfer_ok(ahb_addr_in, ahb_size_in);
  assign done_s    = (state_r == ACCESS) & slv_ready_in & ~slv_error_in;
  // A new address phase is only accepted where the previous data phase is over.
  assign capture_s = sample_s & ((state_r == IDLE) | (state_r == ERR2) | done_s);

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, ERR2: begin
        if (sample_s) begin
          state_nxt_s = valid_s ? ACCESS : ERR1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        if (slv_ready_in) begin
          if (slv_error_in) begin
            state_nxt_s = ERR1;
          end else if (sample_s) begin
            state_nxt_s = valid_s ? ACCESS : ERR1;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (cnt_r >= TO_LAST) begin
          state_nxt_s = ERR1;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      ERR1:    state_nxt_s = ERR2;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, captured address phase, wait counter and held read data.
  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      state_r <= IDLE;
      addr_r  <= '0;
      write_r <= 1'b0;
      size_r  <= 3'd0;
      cnt_r   <= 8'd0;
      rdata_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (capture_s) begin
        addr_r  <= ahb_addr_in;
        write_r <= ahb_write_in;
        size_r  <= ahb_size_in;
      end
      if (state_nxt_s == ACCESS && (state_r != ACCESS || done_s)) begin
        cnt_r <= 8'd0;
      end else if (state_r == ACCESS && !slv_ready_in && cnt_r != 8'hFF) begin
        cnt_r <= cnt_r + 8'd1;
      end
      if (done_s) begin
        rdata_r <= write_r ? '0 : slv_rdata_in;
      end
    end
  end

  // Bus response decode; read data is forwarded in the completing cycle.
  always_comb begin
    case (state_r)
      IDLE:    ahb_readyout_out = 1'b1;
      ACCESS:  ahb_readyout_out = slv_ready_in & ~slv_error_in;
      ERR1:    ahb_readyout_out = 1'b0;
      default: ahb_readyout_out = 1'b1;
    endcase
    ahb_resp_out = (state_r == ERR1) | (state_r == ERR2);
    if (done_s) begin
      ahb_rdata_out = write_r ? '0 : slv_rdata_in;
    end else begin
      ahb_rdata_out = rdata_r;
    end
  end

  assign slv_valid_out = (state_r == ACCESS);
  assign slv_write_out = write_r;
  assign slv_addr_out  = addr_r;
  assign slv_size_out  = size_r;
  assign slv_wdata_out = slv_valid_out ? ahb_wdata_in : '0;
  assign slv_strb_out  = slv_valid_out ? ahb_strb_in : '0;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Bench for ahb_slave_if: directed bus scenarios with literal expectations, then
// random traffic checked every cycle against a transfer-level model.
module tb_ahb_slave_if;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          ahb_clk, ahb_rstn;
  logic          ahb_sel, ahb_write, ahb_ready;
  logic [AW-1:0] ahb_addr;
  logic [1:0]    ahb_trans;
  logic [2:0]    ahb_size, ahb_burst;
  logic [3:0]    ahb_strb;
  logic [DW-1:0] ahb_wdata;
  logic          ahb_readyout, ahb_resp;
  logic [DW-1:0] ahb_rdata;
  logic          slv_valid, slv_write, slv_ready, slv_error;
  logic [AW-1:0] slv_addr;
  logic [2:0]    slv_size;
  logic [3:0]    slv_strb;
  logic [DW-1:0] slv_wdata, slv_rdata;

  int n_chk = 0;
  int n_pass = 0;

  ahb_slave_if #(.AHB_ADDR_WIDTH(AW), .AHB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .ahb_clk_in(ahb_clk), .ahb_rstn_in(ahb_rstn), .ahb_sel_in(ahb_sel),
    .ahb_addr_in(ahb_addr), .ahb_trans_in(ahb_trans), .ahb_write_in(ahb_write),
    .ahb_size_in(ahb_size), .ahb_burst_in(ahb_burst), .ahb_strb_in(ahb_strb),
    .ahb_wdata_in(ahb_wdata), .ahb_ready_in(ahb_ready),
    .ahb_readyout_out(ahb_readyout), .ahb_resp_out(ahb_resp), .ahb_rdata_out(ahb_rdata),
    .slv_valid_out(slv_valid), .slv_write_out(slv_write), .slv_addr_out(slv_addr),
    .slv_size_out(slv_size), .slv_strb_out(slv_strb), .slv_wdata_out(slv_wdata),
    .slv_ready_in(slv_ready), .slv_error_in(slv_error), .slv_rdata_in(slv_rdata)
  );

  // Single slave on the bus: HREADY is this slave's HREADYOUT.
  assign ahb_ready = ahb_readyout;

  initial begin
    ahb_clk = 1'b0;
    forever #5 ahb_clk = ~ahb_clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input logic [1:0] trans, input logic wr, input logic [2:0] size,
                      input logic [AW-1:0] addr, input logic sr, input logic se,
                      input logic [DW-1:0] srd, input logic [DW-1:0] wd, input logic [3:0] st);
    @(posedge ahb_clk);
    #1;
    ahb_sel = 1'b1; ahb_trans = trans; ahb_write = wr; ahb_size = size; ahb_addr = addr;
    slv_ready = sr; slv_error = se; slv_rdata = srd; ahb_wdata = wd; ahb_strb = st;
  endtask

  // Transfer-level model: at most one data phase in flight, an error pair, or nothing.
  int            m_err;
  bit            m_busy;
  int            m_wait;
  logic [AW-1:0] m_addr;
  logic          m_wr;
  logic [2:0]    m_size;
  logic [DW-1:0] m_hold;
  logic          e_ready, e_resp, e_valid, done, accept;
  logic [DW-1:0] e_rdata;

  always @(negedge ahb_clk) begin
    if (!ahb_rstn) begin
      m_err = 0; m_busy = 1'b0; m_wait = 0; m_hold = '0;
      chk("rst_readyout", ahb_readyout, 1);
      chk("rst_resp", ahb_resp, 0);
      chk("rst_valid", slv_valid, 0);
      chk("rst_rdata", ahb_rdata, 0);
    end else begin
      e_ready = 1'b1; e_resp = 1'b0; e_valid = 1'b0; done = 1'b0;
      if (m_err == 1) begin
        e_ready = 1'b0; e_resp = 1'b1;
      end else if (m_err == 2) begin
        e_resp = 1'b1;
      end else if (m_busy) begin
        e_valid = 1'b1;
        e_ready = slv_ready && !slv_error;
        done = e_ready;
      end
      e_rdata = m_hold;
      if (done) e_rdata = m_wr ? '0 : slv_rdata;
      chk("readyout", ahb_readyout, e_ready);
      chk("resp", ahb_resp, e_resp);
      chk("valid", slv_valid, e_valid);
      chk("rdata", ahb_rdata, e_rdata);
      if (e_valid) begin
        chk("slv_addr", slv_addr, m_addr);
        chk("slv_write", slv_write, m_wr);
        chk("slv_size", slv_size, m_size);
        chk("slv_wdata", slv_wdata, ahb_wdata);
        chk("slv_strb", slv_strb, ahb_strb);
      end
      m_hold = e_rdata;
      accept = ahb_sel && e_ready && ahb_trans[1];
      if (m_err == 1) begin
        m_err = 2;
      end else if (m_busy && !done) begin
        if (slv_ready) begin
          m_busy = 1'b0; m_err = 1;
        end else begin
          m_wait++;
          if (m_wait >= TO) begin
            m_busy = 1'b0; m_err = 1;
          end
        end
      end else begin
        m_busy = 1'b0; m_err = 0;
        if (accept) begin
          m_addr = ahb_addr; m_wr = ahb_write; m_size = ahb_size;
          if (ahb_size <= 3'd2 && (ahb_addr % (32'd1 << ahb_size)) == 0) begin
            m_busy = 1'b1; m_wait = 0;
          end else begin
            m_err = 1;
          end
        end
      end
    end
  end

  logic          hr;
  logic [2:0]    rs;
  logic [AW-1:0] ra;
  int            thr;

  initial begin
    ahb_rstn = 1'b0; ahb_sel = 1'b0; ahb_trans = 2'd0; ahb_write = 1'b0; ahb_size = 3'd0;
    ahb_addr = '0; ahb_burst = 3'd0; ahb_strb = 4'h0; ahb_wdata = '0;
    slv_ready = 1'b0; slv_error = 1'b0; slv_rdata = '0;
    repeat (3) @(posedge ahb_clk);
    #2 ahb_rstn = 1'b1;
    step(2'd0, 1'b0, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Write with two backend wait states.
    step(2'd2, 1'b1, 3'd2, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge ahb_clk) chk("t1_idle_ready", ahb_readyout, 1);
    for (int i = 0; i < 3; i++) begin
      step(2'd0, 1'b0, 3'd2, 32'h0, (i == 2), 1'b0, 32'h0, 32'hDEADBEEF, 4'hF);
      @(negedge ahb_clk);
      chk("t1_valid", slv_valid, 1);
      chk("t1_readyout", ahb_readyout, (i == 2));
      chk("t1_addr", slv_addr, 32'h10);
      chk("t1_write", slv_write, 1);
      chk("t1_wdata", slv_wdata, 32'hDEADBEEF);
    end
    step(2'd0, 1'b0, 3'd2, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge ahb_clk) chk("t1_valid_drop", slv_valid, 0);

    // Pipelined zero-wait reads.
    step(2'd2, 1'b0, 3'd2, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    step(2'd2, 1'b0, 3'd2, 32'h4, 1'b1, 1'b0, 32'h11111111, 32'h0, 4'h0);
    @(negedge ahb_clk);
    chk("t2_rd0_ready", ahb_readyout, 1);
    chk("t2_rd0_data", ahb_rdata, 32'h11111111);
    chk("t2_rd0_addr", slv_addr, 32'h0);
    step(2'd0, 1'b0, 3'd2, 32'h0, 1'b1, 1'b0, 32'h22222222, 32'h0, 4'h0);
    @(negedge ahb_clk);
    chk("t2_rd1_valid", slv_valid, 1);
    chk("t2_rd1_addr", slv_addr, 32'h4);
    chk("t2_rd1_data", ahb_rdata, 32'h22222222);
    step(2'd0, 1'b0, 3'd2, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge ahb_clk) chk("t2_rdata_hold", ahb_rdata, 32'h22222222);

    // Misaligned read.
    step(2'd2, 1'b0, 3'd2, 32'h2, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    step(2'd0, 1'b0, 3'd2, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge ahb_clk);
    chk("t3_err1_ready", ahb_readyout, 0);
    chk("t3_err1_resp", ahb_resp, 1);
    chk("t3_err1_valid", slv_valid, 0);
    step(2'd0, 1'b0, 3'd2, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge ahb_clk);
    chk("t3_err2_ready", ahb_readyout, 1);
    chk("t3_err2_resp", ahb_resp, 1);
    chk("t3_err2_valid", slv_valid, 0);

    // Backend error, then a NONSEQ accepted during ERR2.
    step(2'd2, 1'b0, 3'd2, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step(2'd0, 1'b0, 3'd2, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0, 4'h0);
    @(negedge ahb_clk) chk("t4_acc_ready", ahb_readyout, 0);
    step(2'd0, 1'b0, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge ahb_clk) chk("t4_err1_resp", {ahb_readyout, ahb_resp}, 2'b01);
    step(2'd2, 1'b0, 3'd2, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge ahb_clk) chk("t4_err2_resp", {ahb_readyout, ahb_resp}, 2'b11);
    step(2'd0, 1'b0, 3'd2, 32'h0, 1'b1, 1'b0, 32'h33333333, 32'h0, 4'h0);
    @(negedge ahb_clk);
    chk("t4_rd_addr", slv_addr, 32'h8);
    chk("t4_rd_ok", {slv_valid, ahb_readyout, ahb_resp}, 3'b110);
    chk("t4_rd_data", ahb_rdata, 32'h33333333);

    // Backend never ready: timeout.
    step(2'd2, 1'b1, 3'd2, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < TO; i++) begin
      step(2'd0, 1'b0, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge ahb_clk) chk("t5_wait", {slv_valid, ahb_readyout}, 2'b10);
    end
    step(2'd0, 1'b0, 3'd2, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge ahb_clk) chk("t5_err1", {slv_valid, ahb_readyout, ahb_resp}, 3'b001);
    step(2'd0, 1'b0, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge ahb_clk) chk("t5_err2", {slv_valid, ahb_readyout, ahb_resp}, 3'b011);
    step(2'd0, 1'b0, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge ahb_clk) chk("t5_idle", {ahb_readyout, ahb_resp}, 2'b10);

    // Asynchronous reset in the middle of a stalled access.
    step(2'd2, 1'b0, 3'd2, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step(2'd0, 1'b0, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1 chk("t6_pre_ready", ahb_readyout, 0);
    #1 ahb_rstn = 1'b0;
    #1;
    chk("t6_rst_ready", ahb_readyout, 1);
    chk("t6_rst_valid", slv_valid, 0);
    chk("t6_rst_rdata", ahb_rdata, 0);
    @(negedge ahb_clk);
    #2 ahb_rstn = 1'b1;
    step(2'd0, 1'b0, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge ahb_clk) chk("t6_post_idle", {ahb_readyout, ahb_resp}, 2'b10);

    // Random traffic; the master holds its address phase while HREADY is low.
    hr = 1'b1;
    thr = 90;
    for (int i = 0; i < 3000; i++) begin
      @(negedge ahb_clk) hr = ahb_readyout;
      @(posedge ahb_clk);
      #1;
      if (i % 250 == 0) thr = (i / 250) % 3 == 0 ? 90 : ((i / 250) % 3 == 1 ? 50 : 20);
      if (hr) begin
        rs = 3'($urandom_range(0, 3));
        ra = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << rs) - 32'd1);
        ahb_sel = ($urandom_range(0, 7) != 0);
        ahb_trans = 2'($urandom_range(0, 3));
        ahb_write = 1'($urandom_range(0, 1));
        ahb_size = rs;
        ahb_addr = ra;
        ahb_burst = 3'($urandom_range(0, 7));
      end
      slv_ready = ($urandom_range(0, 99) < thr);
      slv_error = ($urandom_range(0, 15) == 0);
      slv_rdata = $urandom;
      ahb_wdata = $urandom;
      ahb_strb = 4'($urandom_range(0, 15));
    end
    @(negedge ahb_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
